cic_decim_ctrl: RTL and testbench

Sequencer for the CIC decimator datapath. It gates integrator updates from the input sample strobe, issues comb-stage enables at a programmable decimation ratio, and suppresses the comb warm-up outputs. It buffers each decimated sample in a one-deep valid/ready output register and flags overruns. It sits between the tile I/O and the integrator/comb datapath, and replaces a free-running divided-clock comb update with a single-clock enable scheme.

---
 rtl/cic_pkg.sv | 19 +
 rtl/cic_out_buf.sv | 38 +++
 rtl/cic_decim_ctrl.sv | 97 +++++++++
 tb/tb_cic_decim_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared types and constants for the CIC decimator sequencer and datapath
package cic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    FILL  = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam int MIN_RATIO     = 2;
  localparam int DEFAULT_RATIO = 4;

  // Widths the integrator/comb datapath must agree on
  localparam int CIC_STAGES      = 2;
  localparam int CIC_WIDTH_RATIO = 4;
  localparam int CIC_WIDTH_DATA  = 5;

endpackage

// File: rtl/cic_out_buf.sv
// rtl/cic_out_buf.sv - one-deep valid/ready holding register with sticky overrun flag
module cic_out_buf #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture,
  input  logic [WIDTH-1:0] capture_data,
  input  logic             clear_ovr,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             overrun
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      // A slot is free if empty or being drained this cycle
      if (capture && (!valid || ready)) begin
        data  <= capture_data;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end

      if (clear_ovr) begin
        overrun <= 1'b0;
      end else if (capture && valid && !ready) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cic_decim_ctrl.sv
// rtl/cic_decim_ctrl.sv - CIC decimator sequencer: state machine, phase and warm-up counters, comb enables
module cic_decim_ctrl #(
  parameter int STAGES        = 2,
  parameter int WIDTH_RATIO   = 4,
  parameter int WIDTH_DATA    = 5,
  parameter int DEFAULT_RATIO = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_load,
  input  logic [WIDTH_RATIO-1:0] cfg_ratio,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   in_valid,
  input  logic [WIDTH_DATA-1:0]  comb_data,
  output logic                   dp_clear,
  output logic                   integ_en,
  output logic                   comb_en,
  output logic [WIDTH_DATA-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   overrun,
  output logic                   busy
);
  import cic_pkg::*;

  localparam int FW = (STAGES > 0) ? $clog2(STAGES + 1) : 1;
  localparam logic [WIDTH_RATIO-1:0] RMIN = WIDTH_RATIO'(MIN_RATIO);

  state_t                 state, state_nxt;
  logic [WIDTH_RATIO-1:0] ratio_q;
  logic [WIDTH_RATIO-1:0] phase;
  logic [FW-1:0]          fill_ctr;
  logic                   wrap, cfg_ok, capture, fill_done;

  assign integ_en  = in_valid && (state == FILL || state == RUN);
  assign wrap      = integ_en && (phase == ratio_q - WIDTH_RATIO'(1));
  assign cfg_ok    = cfg_load && (state == IDLE);
  assign capture   = comb_en && (state == RUN);
  assign fill_done = comb_en && (state == FILL) && (int'(fill_ctr) + 1 == STAGES);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CLEAR;
      CLEAR:   state_nxt = (STAGES == 0) ? RUN : FILL;
      FILL:    if (fill_done) state_nxt = RUN;
      default: state_nxt = state;
    endcase
    if (stop) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ratio_q  <= WIDTH_RATIO'(DEFAULT_RATIO);
      phase    <= '0;
      fill_ctr <= '0;
      comb_en  <= 1'b0;
      dp_clear <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      dp_clear <= (state_nxt == CLEAR);
      busy     <= (state_nxt != IDLE);
      // A wrap in the stop cycle must not leak a comb update into IDLE
      comb_en  <= wrap && !stop;

      if (cfg_ok) ratio_q <= (cfg_ratio < RMIN) ? RMIN : cfg_ratio;

      if (stop || state == CLEAR || wrap) begin
        phase <= '0;
      end else if (integ_en) begin
        phase <= phase + WIDTH_RATIO'(1);
      end

      if (state == CLEAR) begin
        fill_ctr <= '0;
      end else if (comb_en && state == FILL && int'(fill_ctr) < STAGES) begin
        fill_ctr <= fill_ctr + FW'(1);
      end
    end
  end

  cic_out_buf #(.WIDTH(WIDTH_DATA)) u_out_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .capture      (capture),
    .capture_data (comb_data),
    .clear_ovr    (cfg_ok || state == CLEAR),
    .data         (out_data),
    .valid        (out_valid),
    .ready        (out_ready),
    .overrun      (overrun)
  );

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// tb/tb_cic_decim_ctrl.sv - table-driven and directed bench for cic_decim_ctrl
module tb_cic_decim_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_load = 1'b0;
  logic [3:0] cfg_ratio = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       in_valid = 1'b0;
  logic [4:0] comb_data = 5'd0;
  logic       out_ready = 1'b0;
  logic       dp_clear, integ_en, comb_en, out_valid, overrun, busy;
  logic [4:0] out_data;

  int errors = 0;
  int checks = 0;

  cic_decim_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_load  (cfg_load),
    .cfg_ratio (cfg_ratio),
    .start     (start),
    .stop      (stop),
    .in_valid  (in_valid),
    .comb_data (comb_data),
    .dp_clear  (dp_clear),
    .integ_en  (integ_en),
    .comb_en   (comb_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [3:0] rat;
    logic       st, sp, iv;
    logic [4:0] cd;
    logic       rdy;
    logic       dpc, ie, ce, ov;
    logic [4:0] od;
    logic       orun, bsy;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t v(input int ld, rat, st, sp, iv, cd, rdy,
                             input int dpc, ie, ce, ov, od, orun, bsy);
    vec_t r;
    r.ld = ld[0]; r.rat = 4'(rat); r.st = st[0]; r.sp = sp[0]; r.iv = iv[0];
    r.cd = 5'(cd); r.rdy = rdy[0];
    r.dpc = dpc[0]; r.ie = ie[0]; r.ce = ce[0]; r.ov = ov[0];
    r.od = 5'(od); r.orun = orun[0]; r.bsy = bsy[0];
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Gap in cycles between the first two comb_en pulses seen
  task automatic measure(output int gap);
    int first;
    first = -1;
    gap = -1;
    for (int c = 0; c < 60 && gap < 0; c++) begin
      tick();
      if (comb_en) begin
        if (first < 0) first = c;
        else gap = c - first;
      end
    end
  endtask

  task automatic load_ratio(input int r);
    cfg_load = 1'b1; cfg_ratio = 4'(r);
    tick();
    cfg_load = 1'b0; cfg_ratio = 4'd0;
  endtask

  initial begin
    int gap;

    // ld rat st sp iv cd rdy | dpc ie ce ov od orun bsy
    tbl[0]  = v(1, 4, 0, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0);
    tbl[1]  = v(0, 0, 1, 0, 0,  0, 0,  1, 0, 0, 0,  0, 0, 1);
    tbl[2]  = v(0, 0, 0, 0, 1,  0, 0,  0, 1, 0, 0,  0, 0, 1);
    tbl[3]  = v(0, 0, 0, 0, 1,  0, 0,  0, 1, 0, 0,  0, 0, 1);
    tbl[4]  = v(0, 0, 0, 0, 1,  0, 0,  0, 1, 0, 0,  0, 0, 1);
    tbl[5]  = v(0, 0, 0, 0, 1,  0, 0,  0, 1, 0, 0,  0, 0, 1);
    tbl[6]  = v(0, 0, 0, 0, 1,  0, 0,  0, 1, 1, 0,  0, 0, 1);
    tbl[7]  = v(0, 0, 0, 0, 1,  9, 0,  0, 1, 0, 0,  0, 0, 1);
    tbl[8]  = v(0, 0, 0, 0, 1,  0, 0,  0, 1, 0, 0,  0, 0, 1);
    tbl[9]  = v(0, 0, 0, 0, 1,  0, 0,  0, 1, 0, 0,  0, 0, 1);
    tbl[10] = v(0, 0, 0, 0, 1,  0, 0,  0, 1, 1, 0,  0, 0, 1);
    tbl[11] = v(0, 0, 0, 0, 1, 11, 0,  0, 1, 0, 0,  0, 0, 1);
    tbl[12] = v(0, 0, 0, 0, 1,  0, 0,  0, 1, 0, 0,  0, 0, 1);
    tbl[13] = v(0, 0, 0, 0, 1,  0, 0,  0, 1, 0, 0,  0, 0, 1);
    tbl[14] = v(0, 0, 0, 0, 1,  0, 0,  0, 1, 1, 0,  0, 0, 1);
    tbl[15] = v(0, 0, 0, 0, 1, 21, 0,  0, 1, 0, 1, 21, 0, 1);
    tbl[16] = v(0, 0, 0, 0, 1,  0, 1,  0, 1, 0, 0, 21, 0, 1);
    tbl[17] = v(0, 0, 0, 0, 1,  0, 0,  0, 1, 0, 0, 21, 0, 1);
    tbl[18] = v(0, 0, 0, 0, 1,  0, 0,  0, 1, 1, 0, 21, 0, 1);
    tbl[19] = v(0, 0, 0, 0, 1,  7, 0,  0, 1, 0, 1,  7, 0, 1);
    tbl[20] = v(0, 0, 0, 0, 1,  0, 0,  0, 1, 0, 1,  7, 0, 1);
    tbl[21] = v(0, 0, 0, 0, 1,  0, 0,  0, 1, 0, 1,  7, 0, 1);
    tbl[22] = v(0, 0, 0, 0, 1,  0, 0,  0, 1, 1, 1,  7, 0, 1);
    tbl[23] = v(0, 0, 0, 0, 1, 13, 1,  0, 1, 0, 1, 13, 0, 1);
    tbl[24] = v(0, 0, 0, 1, 0,  0, 1,  0, 0, 0, 0, 13, 0, 0);

    // Reset state
    tick(); tick();
    check("rst dp_clear", dp_clear, 0);
    check("rst comb_en", comb_en, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst overrun", overrun, 0);
    check("rst busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;

    // Warm-up, capture, drain and coincident capture/transfer, ratio 4
    for (int i = 0; i < 25; i++) begin
      cfg_load = tbl[i].ld; cfg_ratio = tbl[i].rat; start = tbl[i].st; stop = tbl[i].sp;
      in_valid = tbl[i].iv; comb_data = tbl[i].cd; out_ready = tbl[i].rdy;
      tick();
      check($sformatf("row%0d dp_clear", i), dp_clear, tbl[i].dpc);
      check($sformatf("row%0d integ_en", i), integ_en, tbl[i].ie);
      check($sformatf("row%0d comb_en", i), comb_en, tbl[i].ce);
      check($sformatf("row%0d out_valid", i), out_valid, tbl[i].ov);
      check($sformatf("row%0d out_data", i), out_data, tbl[i].od);
      check($sformatf("row%0d overrun", i), overrun, tbl[i].orun);
      check($sformatf("row%0d busy", i), busy, tbl[i].bsy);
    end
    cfg_load = 0; start = 0; stop = 0; in_valid = 0; out_ready = 1;

    // Ratio clamp: 1 and 0 both give period 2
    for (int r = 1; r >= 0; r--) begin
      load_ratio(r);
      start = 1; tick(); start = 0; in_valid = 1;
      measure(gap);
      check($sformatf("clamp ratio%0d period", r), gap, 2);
      in_valid = 0; stop = 1; tick(); stop = 0;
    end

    // cfg_load outside IDLE is ignored
    load_ratio(4);
    start = 1; tick(); start = 0; in_valid = 1;
    measure(gap);
    check("ratio4 period", gap, 4);
    load_ratio(7);
    measure(gap);
    check("run cfg_load ignored period", gap, 4);
    check("run busy", busy, 1);
    in_valid = 0; stop = 1; tick(); stop = 0;

    // Overrun with consumer stalled, ratio 2
    load_ratio(2);
    out_ready = 0; comb_data = 5;
    start = 1; tick(); start = 0; in_valid = 1;
    for (int c = 0; c < 40 && !out_valid; c++) tick();
    check("ovr first out_valid", out_valid, 1);
    comb_data = 17;
    for (int c = 0; c < 20 && !overrun; c++) tick();
    in_valid = 0; tick(); tick();
    check("ovr overrun", overrun, 1);
    check("ovr out_data kept", out_data, 5);
    check("ovr out_valid held", out_valid, 1);
    out_ready = 1; tick();
    check("ovr drained", out_valid, 0);
    out_ready = 0; stop = 1; tick(); stop = 0;
    check("ovr stop busy", busy, 0);
    check("ovr sticky after stop", overrun, 1);
    start = 1; tick(); start = 0;
    check("restart dp_clear", dp_clear, 1);
    tick();
    check("restart overrun cleared", overrun, 0);
    stop = 1; tick(); stop = 0;

    // Sparse strobes, ratio 3, stop on the boundary strobe
    load_ratio(3);
    out_ready = 1; comb_data = 22;
    start = 1; tick(); start = 0; tick();
    for (int k = 1; k <= 11; k++) begin
      in_valid = 1; tick();
      check($sformatf("sparse k%0d comb_en", k), comb_en, (k % 3 == 0) ? 1 : 0);
      in_valid = 0;
      if (k == 9) out_ready = 0;
      tick();
      check($sformatf("sparse k%0d gap1", k), comb_en, 0);
      tick();
      check($sformatf("sparse k%0d gap2", k), comb_en, 0);
    end
    check("sparse out_valid", out_valid, 1);
    check("sparse out_data", out_data, 22);
    in_valid = 1; stop = 1; tick(); in_valid = 0; stop = 0;
    check("stop comb_en suppressed", comb_en, 0);
    check("stop busy", busy, 0);
    tick();
    check("stop comb_en after", comb_en, 0);
    check("stop out_valid retained", out_valid, 1);
    out_ready = 1; tick();
    check("stop drained", out_valid, 0);

    // Asynchronous reset mid-RUN with data held
    out_ready = 0; comb_data = 9;
    start = 1; tick(); start = 0; in_valid = 1;
    for (int c = 0; c < 60 && !out_valid; c++) tick();
    check("prerst out_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async out_valid", out_valid, 0);
    check("async out_data", out_data, 0);
    check("async busy", busy, 0);
    check("async integ_en", integ_en, 0);
    check("async comb_en", comb_en, 0);
    check("async overrun", overrun, 0);
    in_valid = 0;
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1;
    start = 1; tick(); start = 0; in_valid = 1;
    measure(gap);
    check("post-reset default period", gap, 4);
    in_valid = 0; stop = 1; tick(); stop = 0;

    // start and stop together from IDLE
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    check("start+stop busy", busy, 0);
    check("start+stop dp_clear", dp_clear, 0);
    tick();
    check("start+stop busy later", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
